// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 4-bit upstream sequencer.
// Holds the controller state encoding, bus widths and the power-on init ROM.
package lcd_pkg;

  localparam int CMD_W    = 5;
  localparam int DLY_W    = 21;
  localparam int INIT_LEN = 12;
  localparam int IDX_W    = 4;

  localparam int DEF_NIBBLE_DELAY = 50;
  localparam int DEF_BYTE_DELAY   = 2000;
  localparam int DEF_CLEAR_DELAY  = 82000;

  typedef enum logic [3:0] {
    POWER_WAIT,
    INIT_ISSUE,
    INIT_WAIT,
    INIT_GAP,
    READY,
    HI_ISSUE,
    HI_WAIT,
    HI_GAP,
    LO_ISSUE,
    LO_WAIT,
    LO_GAP
  } state_t;

  typedef struct packed {
    logic [3:0]       nibble;
    logic [DLY_W-1:0] delay;
  } init_entry_t;

  // Three wake-up 0x3 nibbles, switch to 4-bit, then 0x28, 0x0C, 0x01, 0x06 split into nibbles.
  localparam init_entry_t INIT_ROM [INIT_LEN] = '{
    '{4'h3, 21'd205000},
    '{4'h3, 21'd5000},
    '{4'h3, DLY_W'(DEF_BYTE_DELAY)},
    '{4'h2, DLY_W'(DEF_BYTE_DELAY)},
    '{4'h2, DLY_W'(DEF_NIBBLE_DELAY)},
    '{4'h8, DLY_W'(DEF_BYTE_DELAY)},
    '{4'h0, DLY_W'(DEF_NIBBLE_DELAY)},
    '{4'hC, DLY_W'(DEF_BYTE_DELAY)},
    '{4'h0, DLY_W'(DEF_NIBBLE_DELAY)},
    '{4'h1, DLY_W'(DEF_CLEAR_DELAY)},
    '{4'h0, DLY_W'(DEF_NIBBLE_DELAY)},
    '{4'h6, DLY_W'(DEF_BYTE_DELAY)}
  };

  // Clear display (0x01) and return home (0x02/0x03) need the long settle time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_if.sv
// Byte-write request bus plus the nibble-transfer bus towards lcd_transfer.
// master = requester/transfer-engine side, slave = lcd_controller.
interface lcd_if;
  import lcd_pkg::*;

  logic             wrValid;
  logic             wrRs;
  logic [7:0]       wrData;
  logic             wrReady;
  logic             initDone;
  logic             sendCommand;
  logic [CMD_W-1:0] command;
  logic [DLY_W-1:0] commandDelay;
  logic             commandDone;

  modport master (
    output wrValid, wrRs, wrData, commandDone,
    input  wrReady, initDone, sendCommand, command, commandDelay
  );

  modport slave (
    input  wrValid, wrRs, wrData, commandDone,
    output wrReady, initDone, sendCommand, command, commandDelay
  );

endinterface

// File: rtl/lcd_init_rom.sv
// Combinational lookup of the power-on init sequence: index -> {RS=0, nibble} and delay.
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [CMD_W-1:0] command,
  output logic [DLY_W-1:0] delay
);

  init_entry_t entry;

  always_comb begin
    entry = '0;
    if (idx < IDX_W'(INIT_LEN)) entry = INIT_ROM[idx];
    command = {1'b0, entry.nibble};
    delay   = entry.delay;
  end

endmodule

// File: rtl/lcd_controller.sv
// Sequencer in front of lcd_transfer: power-on wait, 4-bit init, then byte writes
// split into high/low nibble transfers with a one-cycle gap after every completion.
module lcd_controller
  import lcd_pkg::*;
#(
  parameter int FREQ            = 50000000,
  parameter int POWER_ON_CYCLES = (FREQ / 1000) * 15,
  parameter int NIBBLE_DELAY    = FREQ / 1000000,
  parameter int BYTE_DELAY      = FREQ / 25000,
  parameter int CLEAR_DELAY     = (FREQ / 1000000) * 1640
) (
  input logic   CLK,
  input logic   RST_N,
  lcd_if.slave  bus
);

  localparam logic [DLY_W-1:0] POWER_LAST = DLY_W'(POWER_ON_CYCLES - 1);
  localparam logic [IDX_W-1:0] INIT_LAST  = IDX_W'(INIT_LEN - 1);

  state_t           state;
  logic [DLY_W-1:0] wait_cnt;
  logic [IDX_W-1:0] init_idx;
  logic             rs_q;
  logic [7:0]       data_q;
  logic [CMD_W-1:0] rom_cmd;
  logic [DLY_W-1:0] rom_dly;

  lcd_init_rom u_rom (
    .idx     (init_idx),
    .command (rom_cmd),
    .delay   (rom_dly)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state            <= POWER_WAIT;
      wait_cnt         <= '0;
      init_idx         <= '0;
      rs_q             <= 1'b0;
      data_q           <= '0;
      bus.wrReady      <= 1'b0;
      bus.initDone     <= 1'b0;
      bus.sendCommand  <= 1'b0;
      bus.command      <= '0;
      bus.commandDelay <= '0;
    end else begin
      bus.sendCommand <= 1'b0;
      case (state)
        POWER_WAIT: begin
          if (wait_cnt == POWER_LAST) state <= INIT_ISSUE;
          else wait_cnt <= wait_cnt + 1'b1;
        end
        INIT_ISSUE: begin
          bus.command      <= rom_cmd;
          bus.commandDelay <= rom_dly;
          bus.sendCommand  <= 1'b1;
          state            <= INIT_WAIT;
        end
        INIT_WAIT: if (bus.commandDone) state <= INIT_GAP;
        INIT_GAP: begin
          if (init_idx == INIT_LAST) begin
            bus.initDone <= 1'b1;
            bus.wrReady  <= 1'b1;
            state        <= READY;
          end else begin
            init_idx <= init_idx + 1'b1;
            state    <= INIT_ISSUE;
          end
        end
        READY: begin
          if (bus.wrValid && bus.wrReady) begin
            rs_q        <= bus.wrRs;
            data_q      <= bus.wrData;
            bus.wrReady <= 1'b0;
            state       <= HI_ISSUE;
          end
        end
        HI_ISSUE: begin
          bus.command      <= {rs_q, data_q[7:4]};
          bus.commandDelay <= DLY_W'(NIBBLE_DELAY);
          bus.sendCommand  <= 1'b1;
          state            <= HI_WAIT;
        end
        HI_WAIT: if (bus.commandDone) state <= HI_GAP;
        HI_GAP:  state <= LO_ISSUE;
        LO_ISSUE: begin
          bus.command      <= {rs_q, data_q[3:0]};
          bus.commandDelay <= is_long_cmd(rs_q, data_q) ? DLY_W'(CLEAR_DELAY)
                                                        : DLY_W'(BYTE_DELAY);
          bus.sendCommand  <= 1'b1;
          state            <= LO_WAIT;
        end
        LO_WAIT: if (bus.commandDone) state <= LO_GAP;
        LO_GAP: begin
          bus.wrReady <= 1'b1;
          state       <= READY;
        end
        default: state <= POWER_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_controller.sv
// Bench for lcd_controller: a behavioural lcd_transfer stand-in with programmable
// completion latency, a send/done log, and a transaction-level expected-send model.
module tb_lcd_controller;
  import lcd_pkg::*;

  localparam int P = 100;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  lcd_if bus();

  lcd_controller #(.POWER_ON_CYCLES(P)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int ROM_NIB [12] = '{3, 3, 3, 2, 2, 8, 0, 12, 0, 1, 0, 6};
  int ROM_DLY [12] = '{205000, 5000, 2000, 2000, 50, 2000, 50, 2000, 50, 82000, 50, 2000};

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int send_cyc[$];
  int send_cmd[$];
  int send_dly[$];
  int done_cyc[$];
  int rise_cyc[$];
  int init_rise[$];
  int pulse_err = 0;
  int done_lat = 9;
  int spur_req = 0;

  // Transfer-engine stand-in and observation log, all sampled on the falling edge.
  initial begin
    logic prev_send, prev_ready, prev_init, pending;
    int dcnt, spur_served;
    prev_send = 0; prev_ready = 0; prev_init = 0; pending = 0; dcnt = 0; spur_served = 0;
    bus.commandDone = 1'b0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (bus.sendCommand) begin
        send_cyc.push_back(cyc);
        send_cmd.push_back(int'(bus.command));
        send_dly.push_back(int'(bus.commandDelay));
      end
      if (bus.sendCommand && prev_send) pulse_err++;
      if (bus.wrReady && !prev_ready) rise_cyc.push_back(cyc);
      if (bus.initDone && !prev_init) init_rise.push_back(cyc);
      prev_send = bus.sendCommand;
      prev_ready = bus.wrReady;
      prev_init = bus.initDone;
      bus.commandDone = 1'b0;
      if (!RST_N) pending = 0;
      else if (pending) begin
        if (dcnt == 0) begin
          bus.commandDone = 1'b1;
          done_cyc.push_back(cyc);
          pending = 0;
        end else dcnt--;
      end else if (spur_served != spur_req) begin
        bus.commandDone = 1'b1;
        spur_served++;
      end
      if (bus.sendCommand && RST_N) begin
        pending = 1;
        dcnt = done_lat;
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_lo_delay(input logic rs, input logic [7:0] d);
    if (rs == 1'b0 && d >= 8'h01 && d <= 8'h03) return 82000;
    return 2000;
  endfunction

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!bus.wrReady && t < 2000) begin tick(); t++; end
  endtask

  task automatic release_and_init();
    int n0, d0, i0, rel, t;
    n0 = send_cyc.size(); d0 = done_cyc.size(); i0 = init_rise.size(); t = 0;
    tick();
    RST_N = 1'b1;
    rel = cyc;
    while (init_rise.size() == i0 && t < 5000) begin tick(); t++; end
    check("init_done_seen", int'(init_rise.size() > i0), 1);
    check("init_send_count", send_cyc.size() - n0, 12);
    check("init_done_count", done_cyc.size() - d0, 12);
    if (send_cyc.size() - n0 >= 12 && init_rise.size() > i0) begin
      check("power_wait_len", send_cyc[n0] - rel, P + 1);
      for (int i = 0; i < 12; i++) begin
        check($sformatf("init_cmd%0d", i), send_cmd[n0 + i], ROM_NIB[i]);
        check($sformatf("init_dly%0d", i), send_dly[n0 + i], ROM_DLY[i]);
      end
      check("init_rise_lat", init_rise[$] - done_cyc[$], 2);
    end
    check("ready_after_init", int'(bus.wrReady), 1);
  endtask

  task automatic do_write(input logic rs, input logic [7:0] d, input int lat);
    int n0, r0, a, t;
    done_lat = lat;
    wait_ready();
    n0 = send_cyc.size(); r0 = rise_cyc.size(); t = 0;
    bus.wrRs = rs; bus.wrData = d; bus.wrValid = 1'b1;
    a = cyc;
    tick();
    bus.wrValid = 1'b0;
    check("ready_drop", int'(bus.wrReady), 0);
    while (rise_cyc.size() == r0 && t < 2000) begin tick(); t++; end
    check("wr_complete", int'(rise_cyc.size() > r0), 1);
    check("wr_send_count", send_cyc.size() - n0, 2);
    if (send_cyc.size() - n0 == 2 && rise_cyc.size() > r0) begin
      check("hi_cmd", send_cmd[n0], int'({rs, d[7:4]}));
      check("hi_dly", send_dly[n0], 50);
      check("lo_cmd", send_cmd[n0 + 1], int'({rs, d[3:0]}));
      check("lo_dly", send_dly[n0 + 1], exp_lo_delay(rs, d));
      check("hi_latency", send_cyc[n0] - a, 2);
      check("ready_rise_lat", rise_cyc[r0] - done_cyc[$], 2);
      check("lo_gap", int'(send_cyc[n0 + 1] - done_cyc[$ - 1] >= 3), 1);
    end
  endtask

  initial begin
    int n0, r0, d0, a, t, s0;
    logic [7:0] da, db;
    logic rsa, rsb;
    bus.wrValid = 1'b0; bus.wrRs = 1'b0; bus.wrData = '0;

    repeat (3) tick();
    check("rst_send", int'(bus.sendCommand), 0);
    check("rst_cmd", int'(bus.command), 0);
    check("rst_dly", int'(bus.commandDelay), 0);
    check("rst_ready", int'(bus.wrReady), 0);
    check("rst_initdone", int'(bus.initDone), 0);

    release_and_init();

    do_write(1'b1, 8'h41, 9);
    do_write(1'b0, 8'h01, 9);
    do_write(1'b1, 8'h01, 9);

    for (int i = 0; i < 6; i++) begin
      rsa = 1'($urandom_range(0, 1));
      da = (i % 3 == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      do_write(rsa, da, $urandom_range(0, 12));
    end

    // Completion pulse while idle must not disturb READY.
    wait_ready();
    s0 = send_cyc.size(); r0 = rise_cyc.size();
    spur_req++;
    repeat (6) tick();
    check("spurious_no_send", send_cyc.size() - s0, 0);
    check("spurious_ready", int'(bus.wrReady), 1);
    check("spurious_no_rise", rise_cyc.size() - r0, 0);

    // wrValid held across two bytes with immediate completions.
    done_lat = 0;
    wait_ready();
    da = 8'($urandom); db = 8'($urandom_range(1, 3));
    rsa = 1'($urandom_range(0, 1)); rsb = 1'b0;
    n0 = send_cyc.size(); r0 = rise_cyc.size(); d0 = done_cyc.size(); t = 0;
    bus.wrRs = rsa; bus.wrData = da; bus.wrValid = 1'b1;
    a = cyc;
    tick();
    bus.wrRs = rsb; bus.wrData = db;
    while (rise_cyc.size() == r0 && t < 2000) begin tick(); t++; end
    tick();
    bus.wrValid = 1'b0;
    check("held_ready_drop", int'(bus.wrReady), 0);
    t = 0;
    while (rise_cyc.size() < r0 + 2 && t < 2000) begin tick(); t++; end
    check("held_send_count", send_cyc.size() - n0, 4);
    if (send_cyc.size() - n0 == 4 && rise_cyc.size() >= r0 + 2 && done_cyc.size() - d0 >= 4) begin
      check("held_a_hi", send_cmd[n0], int'({rsa, da[7:4]}));
      check("held_a_lo", send_cmd[n0 + 1], int'({rsa, da[3:0]}));
      check("held_a_lo_dly", send_dly[n0 + 1], exp_lo_delay(rsa, da));
      check("held_b_hi", send_cmd[n0 + 2], int'({rsb, db[7:4]}));
      check("held_b_lo", send_cmd[n0 + 3], int'({rsb, db[3:0]}));
      check("held_b_lo_dly", send_dly[n0 + 3], 82000);
      check("held_a_lat", send_cyc[n0] - a, 2);
      check("held_b_after_gap", send_cyc[n0 + 2] - rise_cyc[r0], 2);
      for (int i = 1; i < 4; i++)
        check($sformatf("held_gap%0d", i), int'(send_cyc[n0 + i] - done_cyc[d0 + i - 1] >= 3), 1);
    end

    // Reset in the middle of the high-nibble wait.
    done_lat = 9;
    wait_ready();
    n0 = send_cyc.size(); t = 0;
    bus.wrRs = 1'b1; bus.wrData = 8'($urandom); bus.wrValid = 1'b1;
    tick();
    bus.wrValid = 1'b0;
    while (send_cyc.size() == n0 && t < 2000) begin tick(); t++; end
    repeat (3) tick();
    check("pre_rst_initdone", int'(bus.initDone), 1);
    RST_N = 1'b0;
    #1;
    check("arst_send", int'(bus.sendCommand), 0);
    check("arst_cmd", int'(bus.command), 0);
    check("arst_dly", int'(bus.commandDelay), 0);
    check("arst_ready", int'(bus.wrReady), 0);
    check("arst_initdone", int'(bus.initDone), 0);
    repeat (4) tick();
    release_and_init();

    check("send_pulse_width", pulse_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
